// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART transmitter fed by a byte FIFO.
// CPU writes land in a circular buffer; the serializer pops one byte per
// frame and shifts it out LSB first behind a start bit and ahead of a stop bit.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit (8E1).
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr_valid,
    input  logic [7:0]                  wr_data,
    output logic                        wr_ready,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]    FULL_COUNT  = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              push;
    logic              pop;

    // A full FIFO never accepts, even if the serializer pops on the same edge.
    assign wr_ready = (fifo_count != FULL_COUNT);
    assign push     = wr_valid && wr_ready;
    assign pop      = (state == S_IDLE) && (fifo_count != '0);
    assign busy     = (state != S_IDLE) || (fifo_count != '0);

    // Byte storage: written at the tail on every accepted write.
    // NOTE: the storage array has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO bookkeeping: pointers wrap naturally, count tracks queued bytes.
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    // Even parity of the byte, captured when it leaves the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_bit <= 1'b0;
        end else if (pop) begin
            parity_bit <= ^mem[rd_ptr];
        end
    end
`endif

    // Frame sequencer: every non-idle state lasts CLKS_PER_BIT cycles; uart_tx is registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        bit_idx  <= '0;
                        baud_cnt <= BAUD_RELOAD;
                        uart_tx  <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        uart_tx  <= shift[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            uart_tx <= parity_bit;
                            state   <= S_PARITY;
`else
                            uart_tx <= 1'b1;
                            state   <= S_STOP;
`endif
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            uart_tx <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        uart_tx  <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                // NOTE: the default arm returns any unused encoding to a safe idle line.
                default: begin
                    state   <= S_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Reference model: per accepted byte, its accept edge and the edge at which it
// starts on the line (max(accept+1, previous start + frame + 1)); outputs are
// derived from those timestamps arithmetically. A line monitor decodes frames.
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data  = 8'h00;
    logic       wr_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .uart_tx   (uart_tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 25)
                $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         edge_n;
    int         last_start;
    int         m_acc[$];
    int         m_start[$];
    logic [7:0] m_byte[$];
    logic [7:0] exp_q[$];

    function automatic int m_count(input int t);
        int c = 0;
        foreach (m_acc[i]) begin
            if (m_acc[i] <= t) c++;
            if (m_start[i] <= t) c--;
        end
        return c;
    endfunction

    function automatic logic m_busy(input int t);
        if (m_count(t) != 0) return 1'b1;
        foreach (m_start[i])
            if (t >= m_start[i] && t < m_start[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_tx(input int t);
        foreach (m_start[i]) begin
            if (t >= m_start[i] && t < m_start[i] + FRAME) begin
                int bi;
                bi = (t - m_start[i]) / CPB;
                if (bi == 0) return 1'b0;
                if (bi <= 8) return m_byte[i][bi-1];
                if (PAR && bi == 9) return ^m_byte[i];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    task automatic m_reset();
        edge_n     = 0;
        last_start = -100000;
        m_acc.delete();
        m_start.delete();
        m_byte.delete();
        exp_q.delete();
    endtask

    // ---------------- line monitor ----------------
    logic [7:0] rx_q[$];
    logic       rx_ok[$];
    int         rx_base = 0;

    task automatic mon_wait(input int n, inout logic ab);
        repeat (n) begin
            @(negedge clk);
            if (!reset_n) ab = 1'b1;
        end
    endtask

    initial begin : monitor
        logic [7:0] b;
        logic       ab;
        logic       ok;
        forever begin
            @(negedge clk);
            if (reset_n && uart_tx == 1'b0) begin
                ab = 1'b0;
                ok = 1'b1;
                mon_wait(CPB / 2, ab);
                if (uart_tx != 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CPB, ab);
                    b[i] = uart_tx;
                end
`ifdef UART_TX_PARITY_EN
                mon_wait(CPB, ab);
                if (uart_tx != ^b) ok = 1'b0;
`endif
                mon_wait(CPB, ab);
                if (uart_tx != 1'b1) ok = 1'b0;
                if (!ab) begin
                    rx_q.push_back(b);
                    rx_ok.push_back(ok);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic v, input logic [7:0] d, output logic acc);
        int s;
        wr_valid = v;
        wr_data  = d;
        acc = v && (m_count(edge_n) != DEPTH);
        @(posedge clk);
        edge_n++;
        if (acc) begin
            s = (edge_n + 1 > last_start + FRAME + 1) ? edge_n + 1 : last_start + FRAME + 1;
            m_acc.push_back(edge_n);
            m_start.push_back(s);
            m_byte.push_back(d);
            exp_q.push_back(d);
            last_start = s;
        end
        @(negedge clk);
        check("wr_ready", wr_ready, m_count(edge_n) != DEPTH);
        check("fifo_count", fifo_count, m_count(edge_n));
        check("busy", busy, m_busy(edge_n));
        check("uart_tx", uart_tx, m_tx(edge_n));
    endtask

    task automatic put(input logic [7:0] d);
        logic a;
        step(1'b1, d, a);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, a);
    endtask

    task automatic drain();
        logic a;
        int   n = 0;
        while ((m_count(edge_n) != 0 || edge_n < last_start + FRAME + 2) && n < 3000) begin
            step(1'b0, 8'h00, a);
            n++;
        end
        idle(2);
        m_acc.delete();
        m_start.delete();
        m_byte.delete();
    endtask

    task automatic check_rx();
        check("rx_count", rx_q.size() - rx_base, exp_q.size());
        foreach (exp_q[i]) begin
            if (rx_base + i < rx_q.size()) begin
                check("rx_byte", rx_q[rx_base+i], exp_q[i]);
                check("rx_framing", rx_ok[rx_base+i], 1'b1);
            end
        end
        rx_base = rx_q.size();
        exp_q.delete();
    endtask

    // ---------------- directed table for a single 0x55 frame ----------------
    typedef struct {
        int         k;
        logic       tx;
        logic       bsy;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl [20];
    int   n_tbl;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        logic a;
        int   k;
        int   sent;
        int   guard;
        int   rate;

        // k = edges after the write edge N; values as seen after edge N+k.
        tbl[0]  = '{0,  1'b1, 1'b1, 3'd1};
        tbl[1]  = '{1,  1'b0, 1'b1, 3'd0};
        tbl[2]  = '{4,  1'b0, 1'b1, 3'd0};
        tbl[3]  = '{5,  1'b1, 1'b1, 3'd0};
        tbl[4]  = '{8,  1'b1, 1'b1, 3'd0};
        tbl[5]  = '{9,  1'b0, 1'b1, 3'd0};
        tbl[6]  = '{13, 1'b1, 1'b1, 3'd0};
        tbl[7]  = '{17, 1'b0, 1'b1, 3'd0};
        tbl[8]  = '{21, 1'b1, 1'b1, 3'd0};
        tbl[9]  = '{25, 1'b0, 1'b1, 3'd0};
        tbl[10] = '{29, 1'b1, 1'b1, 3'd0};
        tbl[11] = '{33, 1'b0, 1'b1, 3'd0};
        tbl[12] = '{36, 1'b0, 1'b1, 3'd0};
`ifdef UART_TX_PARITY_EN
        tbl[13] = '{37, 1'b0, 1'b1, 3'd0};
        tbl[14] = '{40, 1'b0, 1'b1, 3'd0};
        tbl[15] = '{41, 1'b1, 1'b1, 3'd0};
        tbl[16] = '{44, 1'b1, 1'b1, 3'd0};
        tbl[17] = '{45, 1'b1, 1'b0, 3'd0};
        n_tbl = 18;
`else
        tbl[13] = '{37, 1'b1, 1'b1, 3'd0};
        tbl[14] = '{40, 1'b1, 1'b1, 3'd0};
        tbl[15] = '{41, 1'b1, 1'b0, 3'd0};
        n_tbl = 16;
`endif

        // Reset held for 8 cycles.
        m_reset();
        reset_n = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_fifo_count", fifo_count, 3'd0);
        reset_n = 1'b1;
        m_reset();
        idle(3);

        // Single byte 0x55 against the table.
        put(8'h55);
        k = 0;
        for (int j = 0; j < n_tbl; j++) begin
            while (k < tbl[j].k) begin
                step(1'b0, 8'h00, a);
                k++;
            end
            check("tbl_uart_tx", uart_tx, tbl[j].tx);
            check("tbl_busy", busy, tbl[j].bsy);
            check("tbl_fifo_count", fifo_count, tbl[j].cnt);
        end
        drain();
        check_rx();

        // Burst "ABC" on consecutive cycles.
        put(8'h41);
        put(8'h42);
        put(8'h43);
        check("burst_peak_count", fifo_count, 3'd2);
        drain();
        check_rx();

        // Full FIFO: six writes, the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            put(8'h60 + 8'(i));
            if (i == 4) check("full_ready_after_5th", wr_ready, 1'b0);
        end
        check("full_count_after_6th", fifo_count, 3'd4);
        drain();
        check("full_tx_bytes", rx_q.size() - rx_base, 5);
        check_rx();

        // Pointer wrap: 20 bytes under flow control.
        sent  = 0;
        guard = 0;
        while (sent < 20 && guard < 3000) begin
            step(1'b1, 8'(sent), a);
            if (a) sent++;
            guard++;
        end
        check("wrap_sent", sent, 20);
        drain();
        check_rx();

`ifdef UART_TX_PARITY_EN
        // Parity bit values and frame length.
        put(8'h07);
        idle(37);
        check("parity_07", uart_tx, 1'b1);
        idle(7);
        check("parity_frame_busy_44", busy, 1'b1);
        idle(1);
        check("parity_frame_busy_45", busy, 1'b0);
        put(8'h03);
        idle(37);
        check("parity_03", uart_tx, 1'b0);
        drain();
        check_rx();
`endif

        // Randomized traffic at varying write rates.
        for (int ph = 0; ph < 3; ph++) begin
            rate = (ph == 1) ? 70 : 12;
            for (int c = 0; c < 500; c++)
                step($urandom_range(0, 99) < rate, 8'($urandom), a);
        end
        drain();
        check_rx();

        // Reset mid-frame with bytes still queued.
        put(8'h00);
        put(8'h00);
        put(8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_uart_tx", uart_tx, 1'b1);
        check("midrst_fifo_count", fifo_count, 3'd0);
        check("midrst_busy", busy, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        idle(50);
        rx_base = rx_q.size();
        put(8'h5A);
        drain();
        check_rx();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Synthesizable 8N1 UART transmitter with a byte FIFO. It sits between the CPU's memory-mapped UART data register and the `uart_tx` pin, and produces the serial stream that the simulation `uart_output` decoder consumes. CPU writes are buffered so that software can issue several bytes back-to-back without polling every bit time.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range is ≥ 2.
- `FIFO_DEPTH`, default 16: byte FIFO entries. Must be a power of two and ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_valid`  in  1  the CPU presents a byte.
- `wr_data`  in  8  byte to transmit.
- `wr_ready`  out  1  FIFO can accept a byte. A write is accepted on any edge where `wr_valid && wr_ready`.
- `uart_tx`  out  1  serial line. It idles high.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes currently queued, excluding the byte being shifted.

## Operation
- FIFO:
  - Circular buffer with read/write pointers of width $clog2(FIFO_DEPTH); both wrap modulo FIFO_DEPTH.
  - `fifo_count` is a registered count.
  - `wr_ready = (fifo_count != FIFO_DEPTH)`. There is no full bypass: a simultaneous pop does not make a full FIFO accept a write in the same cycle.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
  - Writes while full are ignored. `wr_valid` while `wr_ready` is low is not an error.
- State machine (IDLE, START, DATA, STOP; PARITY when configured):
  - IDLE: `uart_tx=1`. If the FIFO is non-empty, pop the head into the shift register, load the bit counter with 0 and the baud counter with CLKS_PER_BIT-1, then go to START.
  - START: `uart_tx=0`.
  - DATA: `uart_tx = shift[0]`, LSB first, 8 bits. At the end of each bit, shift right and increment the bit index. After bit 7, go to STOP (or PARITY).
  - STOP: `uart_tx=1` for one bit time, then go to IDLE.
  - Every non-IDLE state lasts exactly CLKS_PER_BIT cycles. The baud counter counts down to 0 and reloads with CLKS_PER_BIT-1 on each state or bit transition.
- `uart_tx` is driven from a register, so it is glitch-free.
- `busy = (state != IDLE) || (fifo_count != 0)`.
- Reset values: `uart_tx=1`, `wr_ready=1`, `busy=0`, `fifo_count=0`, state=IDLE, pointers=0.
- Reset asserted mid-frame: the frame is abandoned, `uart_tx` goes high asynchronously, and queued bytes are discarded.

## Timing
- Write accepted at edge N with the FIFO empty and state IDLE:
  - `fifo_count` becomes 1 after edge N.
  - Pop and transition to START happen at edge N+1.
  - `uart_tx` falls after edge N+1, and `fifo_count` returns to 0 after N+1.
- Frame length on the line: 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity).
- Back-to-back frames: STOP → IDLE (exactly 1 cycle) → START. The frame-to-frame period is 10·CLKS_PER_BIT+1 cycles.
- `wr_ready` falls in the cycle after the write that fills the FIFO. It rises in the cycle after the pop that frees an entry.
- `busy` falls one cycle after the STOP bit's last cycle when the FIFO is empty.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state follows DATA and drives the even parity bit, `^data`, for CLKS_PER_BIT cycles.
  - Frame format is 8E1, 11 bits.
- `UART_TX_PARITY_EN` undefined: 8N1, no PARITY state, and no parity logic is synthesized.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4 unless noted.
- Reset: hold `reset_n=0` for 8 cycles. Then `uart_tx=1`, `wr_ready=1`, `busy=0`, `fifo_count=0`. Drive `reset_n` low mid-frame: `uart_tx` is 1 immediately and `fifo_count=0`.
- Single byte 0x55 written at edge N:
  - `uart_tx` low during cycles N+2..N+5, then data bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for the stop bit.
  - `busy` drops at N+42.
  - `uart_output` decodes 0x55.
- Burst 0x41, 0x42, 0x43 on consecutive cycles: `fifo_count` peaks at 2. Frames start 41 cycles apart with a 1-cycle idle gap, and they decode in order as "ABC".
- Full FIFO: write 6 bytes on consecutive cycles.
  - `wr_ready` is 0 after the 5th accept (4 queued plus 1 shifting).
  - The 6th byte is dropped.
  - Exactly 5 bytes are transmitted.
- Pointer wrap: stream 20 bytes 0x00..0x13 with `wr_valid` held high under `wr_ready` flow control. All 20 decode in order and no bytes are lost or duplicated.
- With `UART_TX_PARITY_EN`, byte 0x07: the parity bit is 1 and the frame is 44 cycles. With byte 0x03, the parity bit is 0.
